// File: rtl/btn_sw_conditioner_pkg.sv
// Shared defaults for the button/switch input conditioner.
// Widths and limits here are the board defaults; instances may override them.
package btn_sw_conditioner_pkg;

    localparam int NB_BTN      = 4;
    localparam int NB_SW       = 4;
    localparam int NB_DEB      = 20;
    localparam int DEB_LIMIT   = 2**19;
    localparam int NB_LONG     = 26;
    localparam int LONG_LIMIT  = 2**25;
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/btn_sw_conditioner_if.sv
// Raw button/switch inputs and conditioned level/pulse outputs.
// The master drives the raw inputs; the slave is the conditioner.
interface btn_sw_conditioner_if #(
    parameter int BTN_W = btn_sw_conditioner_pkg::NB_BTN,
    parameter int SW_W  = btn_sw_conditioner_pkg::NB_SW
);

    logic [BTN_W-1:0] i_btn;
    logic [SW_W-1:0]  i_sw;
    logic [BTN_W-1:0] o_btn;
    logic [BTN_W-1:0] o_btn_rise;
    logic [BTN_W-1:0] o_btn_fall;
    logic [SW_W-1:0]  o_sw;
    logic [BTN_W-1:0] o_btn_long;

    modport master (
        output i_btn, i_sw,
        input  o_btn, o_btn_rise, o_btn_fall, o_sw, o_btn_long
    );

    modport slave (
        input  i_btn, i_sw,
        output o_btn, o_btn_rise, o_btn_fall, o_sw, o_btn_long
    );

endinterface

// File: rtl/btn_sw_conditioner_debounce_chan.sv
// One conditioned channel: synchronizer, debounce counter, stable level, edge pulses.
// Long-press detection is built only when BTN_LONG_PRESS_EN is defined.
module debounce_chan #(
    parameter int NB_DEB     = btn_sw_conditioner_pkg::NB_DEB,
    parameter int DEB_LIMIT  = btn_sw_conditioner_pkg::DEB_LIMIT,
    parameter int NB_LONG    = btn_sw_conditioner_pkg::NB_LONG,
    parameter int LONG_LIMIT = btn_sw_conditioner_pkg::LONG_LIMIT
) (
    input  logic clock,
    input  logic ck_rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic long_pulse
);
    import btn_sw_conditioner_pkg::SYNC_STAGES;

    localparam logic [NB_DEB-1:0] DEB_LAST = NB_DEB'(DEB_LIMIT - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [NB_DEB-1:0]      cnt_reg, cnt_next;
    logic                   stable_reg, stable_next;
    logic                   rise_reg, rise_next;
    logic                   fall_reg, fall_next;
    logic                   synced;

    assign synced = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge ck_rst) begin
        if (!ck_rst) begin
            sync_reg   <= '0;
            cnt_reg    <= '0;
            stable_reg <= 1'b0;
            rise_reg   <= 1'b0;
            fall_reg   <= 1'b0;
        end else begin
            sync_reg   <= {sync_reg[SYNC_STAGES-2:0], raw};
            cnt_reg    <= cnt_next;
            stable_reg <= stable_next;
            rise_reg   <= rise_next;
            fall_reg   <= fall_next;
        end
    end

    // Any agreeing sample discards the run, so bounces never accumulate credit.
    always_comb begin
        cnt_next    = cnt_reg;
        stable_next = stable_reg;
        rise_next   = 1'b0;
        fall_next   = 1'b0;
        if (synced == stable_reg) begin
            cnt_next = '0;
        end else if (cnt_reg >= DEB_LAST) begin
            cnt_next    = '0;
            stable_next = synced;
            rise_next   = synced;
            fall_next   = !synced;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    assign level = stable_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

`ifdef BTN_LONG_PRESS_EN
    localparam logic [NB_LONG-1:0] LONG_LAST = NB_LONG'(LONG_LIMIT - 1);

    logic [NB_LONG-1:0] long_cnt_reg;
    logic               long_done_reg;
    logic               long_reg;

    // Counting starts the cycle after the level rises; a release on the same edge wins.
    always_ff @(posedge clock or negedge ck_rst) begin
        if (!ck_rst) begin
            long_cnt_reg  <= '0;
            long_done_reg <= 1'b0;
            long_reg      <= 1'b0;
        end else if (!stable_next) begin
            long_cnt_reg  <= '0;
            long_done_reg <= 1'b0;
            long_reg      <= 1'b0;
        end else if (stable_reg) begin
            if (long_cnt_reg != LONG_LAST) begin
                long_cnt_reg <= long_cnt_reg + 1'b1;
            end
            long_reg <= (long_cnt_reg == LONG_LAST) && !long_done_reg;
            if (long_cnt_reg == LONG_LAST) begin
                long_done_reg <= 1'b1;
            end
        end else begin
            long_reg <= 1'b0;
        end
    end

    assign long_pulse = long_reg;
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: rtl/btn_sw_conditioner.sv
// Board input front end: debounced levels for buttons and switches, press/release pulses
// for buttons, and an optional long-press pulse enabled by BTN_LONG_PRESS_EN.
module btn_sw_conditioner #(
    parameter int NB_BTN     = btn_sw_conditioner_pkg::NB_BTN,
    parameter int NB_SW      = btn_sw_conditioner_pkg::NB_SW,
    parameter int NB_DEB     = btn_sw_conditioner_pkg::NB_DEB,
    parameter int DEB_LIMIT  = btn_sw_conditioner_pkg::DEB_LIMIT,
    parameter int NB_LONG    = btn_sw_conditioner_pkg::NB_LONG,
    parameter int LONG_LIMIT = btn_sw_conditioner_pkg::LONG_LIMIT
) (
    input  logic                  clock,
    input  logic                  ck_rst,
    btn_sw_conditioner_if.slave   bus
);

    for (genvar gi = 0; gi < NB_BTN; gi++) begin : g_btn
        debounce_chan #(
            .NB_DEB    (NB_DEB),
            .DEB_LIMIT (DEB_LIMIT),
            .NB_LONG   (NB_LONG),
            .LONG_LIMIT(LONG_LIMIT)
        ) u_chan (
            .clock     (clock),
            .ck_rst    (ck_rst),
            .raw       (bus.i_btn[gi]),
            .level     (bus.o_btn[gi]),
            .rise      (bus.o_btn_rise[gi]),
            .fall      (bus.o_btn_fall[gi]),
            .long_pulse(bus.o_btn_long[gi])
        );
    end

    // Switches are level-only; their pulse outputs have no consumer.
    for (genvar gi = 0; gi < NB_SW; gi++) begin : g_sw
        debounce_chan #(
            .NB_DEB    (NB_DEB),
            .DEB_LIMIT (DEB_LIMIT),
            .NB_LONG   (NB_LONG),
            .LONG_LIMIT(LONG_LIMIT)
        ) u_chan (
            .clock     (clock),
            .ck_rst    (ck_rst),
            .raw       (bus.i_sw[gi]),
            .level     (bus.o_sw[gi]),
            .rise      (),
            .fall      (),
            .long_pulse()
        );
    end

endmodule

// File: tb/tb_btn_sw_conditioner.sv
// Self-checking bench for btn_sw_conditioner with DEB_LIMIT=4, LONG_LIMIT=8.
// Long-press expectations follow BTN_LONG_PRESS_EN when defined.
module tb_btn_sw_conditioner;

    localparam int DEB = 4;
    localparam int LL  = 8;
    localparam int NB  = 4;
    localparam int NS  = 4;
    localparam int FAR = -100000;

    logic clock  = 1'b0;
    logic ck_rst = 1'b0;
    always #5 clock = ~clock;

    btn_sw_conditioner_if #(.BTN_W(NB), .SW_W(NS)) bus ();

    btn_sw_conditioner #(
        .NB_BTN    (NB),
        .NB_SW     (NS),
        .NB_DEB    (20),
        .DEB_LIMIT (DEB),
        .NB_LONG   (26),
        .LONG_LIMIT(LL)
    ) dut (
        .clock (clock),
        .ck_rst(ck_rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a level is accepted once the delayed input has disagreed with
    // it for DEB consecutive edges since it last agreed (or last changed).
    logic [7:0] raw_q[$];
    int         n_edge;
    int         last_agree[8];
    logic [7:0] s_m;
    int         rise_edge[4];
    logic [3:0] e_rise, e_fall, e_long;

    task automatic model_reset();
        raw_q = {};
        raw_q.push_back(8'h00);
        raw_q.push_back(8'h00);
        n_edge = 0;
        s_m    = '0;
        e_rise = '0;
        e_fall = '0;
        e_long = '0;
        for (int c = 0; c < 8; c++) last_agree[c] = 0;
        for (int c = 0; c < 4; c++) rise_edge[c] = FAR;
    endtask

    task automatic model_edge();
        logic [7:0] v;
        n_edge++;
        raw_q.push_back({bus.i_sw, bus.i_btn});
        v      = raw_q.pop_front();
        e_rise = '0;
        e_fall = '0;
        e_long = '0;
        for (int c = 0; c < 8; c++) begin
            if (v[c] == s_m[c]) begin
                last_agree[c] = n_edge;
            end else if (n_edge - last_agree[c] >= DEB) begin
                s_m[c]        = v[c];
                last_agree[c] = n_edge;
                if (c < 4) begin
                    if (v[c]) begin
                        e_rise[c]    = 1'b1;
                        rise_edge[c] = n_edge;
                    end else begin
                        e_fall[c]    = 1'b1;
                        rise_edge[c] = FAR;
                    end
                end
            end
        end
`ifdef BTN_LONG_PRESS_EN
        for (int c = 0; c < 4; c++)
            if (s_m[c] && (n_edge - rise_edge[c] == LL)) e_long[c] = 1'b1;
`endif
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        check("o_btn",      32'(bus.o_btn),      32'(s_m[3:0]));
        check("o_sw",       32'(bus.o_sw),       32'(s_m[7:4]));
        check("o_btn_rise", 32'(bus.o_btn_rise), 32'(e_rise));
        check("o_btn_fall", 32'(bus.o_btn_fall), 32'(e_fall));
        check("o_btn_long", 32'(bus.o_btn_long), 32'(e_long));
    endtask

    typedef struct {
        logic [3:0] btn;
        logic [3:0] sw;
        int         hold;
        logic [3:0] exp_btn;
        logic [3:0] exp_sw;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises, falls, longs, rise_at, long_at;

        vecs[0] = '{4'h0, 4'h0, 8, 4'h0, 4'h0};
        vecs[1] = '{4'h5, 4'hA, 8, 4'h5, 4'hA};
        vecs[2] = '{4'hF, 4'hF, 3, 4'h5, 4'hA};
        vecs[3] = '{4'h5, 4'hA, 8, 4'h5, 4'hA};
        vecs[4] = '{4'hA, 4'h5, 6, 4'hA, 4'h5};
        vecs[5] = '{4'h0, 4'h0, 5, 4'hA, 4'h5};
        vecs[6] = '{4'h0, 4'h0, 1, 4'h0, 4'h0};

        // Reset with all buttons held.
        bus.i_btn = 4'hF;
        bus.i_sw  = 4'h0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check("reset_o_btn",  32'(bus.o_btn),      0);
        check("reset_o_sw",   32'(bus.o_sw),       0);
        check("reset_rise",   32'(bus.o_btn_rise), 0);
        check("reset_fall",   32'(bus.o_btn_fall), 0);
        check("reset_long",   32'(bus.o_btn_long), 0);
        @(negedge clock);
        ck_rst = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            tick();
            if (t < 6) check("rst_release_btn", 32'(bus.o_btn), 0);
            if (t == 6) begin
                check("rst_release_btn6",  32'(bus.o_btn),      32'hF);
                check("rst_release_rise6", 32'(bus.o_btn_rise), 32'hF);
            end
            if (t == 7) check("rst_release_rise7", 32'(bus.o_btn_rise), 0);
        end
        $display("txn reset_release: o_btn=%h after 6 edges", bus.o_btn);

        // Table vectors.
        for (int i = 0; i < 7; i++) begin
            bus.i_btn = vecs[i].btn;
            bus.i_sw  = vecs[i].sw;
            repeat (vecs[i].hold) tick();
            check("vec_o_btn", 32'(bus.o_btn), 32'(vecs[i].exp_btn));
            check("vec_o_sw",  32'(bus.o_sw),  32'(vecs[i].exp_sw));
            $display("txn vec %0d: btn=%h sw=%h hold=%0d -> o_btn=%h o_sw=%h",
                     i, vecs[i].btn, vecs[i].sw, vecs[i].hold, bus.o_btn, bus.o_sw);
        end

        // Clean press on button 1.
        bus.i_btn = 4'b0010;
        rises = 0; falls = 0; rise_at = 0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (bus.o_btn_rise[1]) begin
                rises++;
                if (rise_at == 0) rise_at = t;
            end
            if (bus.o_btn_fall[1]) falls++;
        end
        check("press_latency", 32'(rise_at), 6);
        check("press_rises",   32'(rises),   1);
        check("press_falls",   32'(falls),   0);
        $display("txn clean_press: rise at edge %0d, rises=%0d falls=%0d", rise_at, rises, falls);
        bus.i_btn = 4'h0;
        repeat (8) tick();

        // Bouncing press on button 2, then a steady hold.
        rises = 0; rise_at = 0;
        for (int p = 0; p < 4; p++) begin
            bus.i_btn[2] = (p % 2 == 0);
            repeat (2) begin
                tick();
                if (bus.o_btn_rise[2]) rises++;
            end
        end
        bus.i_btn[2] = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (bus.o_btn_rise[2]) begin
                rises++;
                if (rise_at == 0) rise_at = t;
            end
        end
        check("bounce_latency", 32'(rise_at), 6);
        check("bounce_rises",   32'(rises),   1);
        $display("txn bounce: rise at edge %0d of hold, rises=%0d", rise_at, rises);
        bus.i_btn = 4'h0;
        repeat (8) tick();

        // Short glitch on switch 0.
        bus.i_sw[0] = 1'b1;
        repeat (3) begin
            tick();
            check("glitch_sw", 32'(bus.o_sw), 0);
        end
        bus.i_sw[0] = 1'b0;
        repeat (8) begin
            tick();
            check("glitch_sw", 32'(bus.o_sw), 0);
        end
        $display("txn glitch: o_sw=%h", bus.o_sw);

        // Simultaneous press on buttons 0 and 3.
        bus.i_btn = 4'b1001;
        rise_at = 0;
        for (int t = 1; t <= 20 && rise_at == 0; t++) begin
            tick();
            if (bus.o_btn_rise != 4'h0) begin
                rise_at = t;
                check("concurrent_rise", 32'(bus.o_btn_rise), 32'h9);
            end
        end
        check("concurrent_latency", 32'(rise_at), 6);
        $display("txn concurrent: rise=%h at edge %0d", bus.o_btn_rise, rise_at);

        // Release, then reset in the middle of the release count.
        bus.i_btn = 4'h0;
        repeat (2) tick();
        #2;
        ck_rst = 1'b0;
        #1;
        check("midrst_o_btn", 32'(bus.o_btn),      0);
        check("midrst_rise",  32'(bus.o_btn_rise), 0);
        check("midrst_fall",  32'(bus.o_btn_fall), 0);
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        ck_rst = 1'b1;
        rises = 0; falls = 0;
        repeat (10) begin
            tick();
            if (bus.o_btn_rise != 4'h0) rises++;
            if (bus.o_btn_fall != 4'h0) falls++;
        end
        check("midrst_post_rises", 32'(rises), 0);
        check("midrst_post_falls", 32'(falls), 0);
        $display("txn mid_reset: o_btn=%h rises=%0d falls=%0d", bus.o_btn, rises, falls);

        // Long hold on button 0, release, press again.
        for (int r = 0; r < 2; r++) begin
            bus.i_btn = 4'b0001;
            longs = 0; rise_at = 0; long_at = 0;
            for (int t = 1; t <= 40; t++) begin
                tick();
                if (bus.o_btn_rise[0] && rise_at == 0) rise_at = t;
                if (bus.o_btn_long[0]) begin
                    longs++;
                    if (long_at == 0) long_at = t;
                end
            end
`ifdef BTN_LONG_PRESS_EN
            check("long_count", 32'(longs), 1);
            check("long_delay", 32'(long_at - rise_at), LL);
`else
            check("long_count", 32'(longs), 0);
`endif
            $display("txn long_hold %0d: rise at %0d, long pulses=%0d first at %0d",
                     r, rise_at, longs, long_at);
            bus.i_btn = 4'h0;
            repeat (10) tick();
        end

        // Randomized input activity with slow toggling so some runs get accepted.
        for (int t = 0; t < 400; t++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) bus.i_btn[b] = ~bus.i_btn[b];
                if ($urandom_range(0, 5) == 0) bus.i_sw[b]  = ~bus.i_sw[b];
            end
            tick();
        end
        $display("txn random: 400 cycles, final o_btn=%h o_sw=%h", bus.o_btn, bus.o_sw);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
